// File: rtl/iodelay_tap_sequencer.sv
// Multi-channel IDELAY/ODELAY tap sequencer with load, readback check and up/down tap sweeps,
// plus the free-running test-trigger generator. Everything runs in the 200 MHz IO clock domain.
module iodelay_tap_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int TAP_W      = 5,
  parameter int SETTLE_CYC = 4,
  parameter int DWELL_CYC  = 16,
  parameter int TRG_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_mode,
  input  logic [NUM_CH-1:0]       cmd_ch_mask,
  input  logic [TAP_W-1:0]        cmd_tap,
  input  logic [TAP_W-1:0]        cmd_step,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       dly_ld,
  output logic [NUM_CH*TAP_W-1:0] dly_cntvaluein,
  input  logic [NUM_CH*TAP_W-1:0] dly_cntvalueout,
  output logic [TAP_W-1:0]        tap_cur,
  output logic                    busy,
  output logic                    step_stb,
  output logic                    done,
  output logic                    err,
  output logic [NUM_CH-1:0]       err_ch,
  input  logic                    trg_en,
  output logic                    trg_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DWELL  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] MODE_UP = 2'd1;
  localparam logic [1:0] MODE_DN = 2'd2;

  localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_INIT  = CNT_W'(DWELL_CYC - 1);

  logic [2:0]              state_q, state_d;
  logic                    sweep_q, sweep_d;
  logic                    up_q, up_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [TAP_W-1:0]        step_q, step_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [NUM_CH*TAP_W-1:0] cntval_q, cntval_d;
  logic [NUM_CH-1:0]       ld_q, ld_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [NUM_CH-1:0]       err_ch_q, err_ch_d;
  logic [TRG_W-1:0]        trg_q, trg_d;
  logic                    live_q, live_d;

  logic                    accept;
  logic [TAP_W:0]          up_sum;
  logic [TAP_W:0]          dn_diff;
  logic                    sweep_last;
  logic [TAP_W-1:0]        tap_next;

  // live_q keeps cmd_ready low while reset is asserted even when rdy is already high
  assign cmd_ready      = (state_q == S_IDLE) && rdy && live_q;
  assign accept         = cmd_valid && cmd_ready;
  assign busy           = (state_q != S_IDLE);
  assign step_stb       = (state_q == S_CHECK) && sweep_q && !abort && rdy;
  assign done           = (state_q == S_DONE) && !abort && rdy;
  assign dly_ld         = ld_q;
  assign dly_cntvaluein = cntval_q;
  assign tap_cur        = tap_q;
  assign err            = err_q;
  assign err_ch         = err_ch_q;
  assign trg_out        = trg_q[TRG_W-1];

  // The extra carry/borrow bit tells us the current tap was the last one of the sweep
  assign up_sum     = {1'b0, tap_q} + {1'b0, step_q};
  assign dn_diff    = {1'b0, tap_q} - {1'b0, step_q};
  assign sweep_last = up_q ? up_sum[TAP_W] : dn_diff[TAP_W];
  assign tap_next   = up_q ? up_sum[TAP_W-1:0] : dn_diff[TAP_W-1:0];

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    up_d     = up_q;
    mask_d   = mask_q;
    step_d   = step_q;
    tap_d    = tap_q;
    cntval_d = cntval_q;
    ld_d     = '0;
    cnt_d    = cnt_q;
    err_d    = err_q;
    err_ch_d = err_ch_q;
    live_d   = 1'b1;
    trg_d    = trg_en ? (trg_q + TRG_W'(1)) : '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sweep_d  = (cmd_mode == MODE_UP) || (cmd_mode == MODE_DN);
          up_d     = (cmd_mode == MODE_UP);
          mask_d   = cmd_ch_mask;
          step_d   = (cmd_step == '0) ? TAP_W'(1) : cmd_step;
          tap_d    = cmd_tap;
          err_d    = 1'b0;
          err_ch_d = '0;
          ld_d     = cmd_ch_mask;
          for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_ch_mask[i]) cntval_d[i*TAP_W +: TAP_W] = cmd_tap;
          end
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = SETTLE_INIT;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CHECK: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (mask_q[i] && (dly_cntvalueout[i*TAP_W +: TAP_W] != tap_q)) begin
            err_ch_d[i] = 1'b1;
            err_d       = 1'b1;
          end
        end
        if (sweep_q) begin
          cnt_d   = DWELL_INIT;
          state_d = S_DWELL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (sweep_last) begin
          state_d = S_DONE;
        end else begin
          tap_d = tap_next;
          ld_d  = mask_q;
          for (int i = 0; i < NUM_CH; i++) begin
            if (mask_q[i]) cntval_d[i*TAP_W +: TAP_W] = tap_next;
          end
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Losing rdy or an abort ends the command at once; the applied tap is left where it was
    if (state_q != S_IDLE) begin
      if (!rdy) begin
        state_d  = S_IDLE;
        err_d    = 1'b1;
        err_ch_d = err_ch_q;
        ld_d     = '0;
        tap_d    = tap_q;
        cntval_d = cntval_q;
      end else if (abort) begin
        state_d  = S_IDLE;
        ld_d     = '0;
        tap_d    = tap_q;
        cntval_d = cntval_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sweep_q  <= 1'b0;
      up_q     <= 1'b0;
      mask_q   <= '0;
      step_q   <= '0;
      tap_q    <= '0;
      cntval_q <= '0;
      ld_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      err_ch_q <= '0;
      trg_q    <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      up_q     <= up_d;
      mask_q   <= mask_d;
      step_q   <= step_d;
      tap_q    <= tap_d;
      cntval_q <= cntval_d;
      ld_q     <= ld_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
      trg_q    <= trg_d;
      live_q   <= live_d;
    end
  end

endmodule

// File: tb/tb_iodelay_tap_sequencer.sv
// Self-checking bench for iodelay_tap_sequencer: table of directed commands plus
// hand-written abort, rdy-loss, trigger and mid-sweep reset sequences.
module tb_iodelay_tap_sequencer;

  localparam int NUM_CH = 4;
  localparam int TAP_W  = 5;
  localparam int NV     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = 2'd0;
  logic [3:0]  cmd_ch_mask = 4'd0;
  logic [4:0]  cmd_tap = 5'd0;
  logic [4:0]  cmd_step = 5'd0;
  logic        abort = 1'b0;
  logic [3:0]  dly_ld;
  logic [19:0] dly_cntvaluein;
  logic [19:0] dly_cntvalueout;
  logic [4:0]  tap_cur;
  logic        busy;
  logic        step_stb;
  logic        done;
  logic        err;
  logic [3:0]  err_ch;
  logic        trg_en = 1'b1;
  logic        trg_out;

  logic [19:0] prim = '0;
  logic        force_ch1 = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] mask;
    logic [4:0] tap;
    logic [4:0] step;
    bit         force_ch1;
    int exp_ld1;
    int exp_ld_count;
    int exp_last_ld;
    int exp_done;
    int exp_nsteps;
    int exp_step_sum;
    int exp_first;
    int exp_last;
    int exp_err;
    int exp_err_ch;
    int exp_tap;
    int exp_cntval;
  } vec_t;

  vec_t vecs [NV];

  iodelay_tap_sequencer #(
    .NUM_CH(NUM_CH), .TAP_W(TAP_W), .SETTLE_CYC(4), .DWELL_CYC(16), .TRG_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_ch_mask(cmd_ch_mask), .cmd_tap(cmd_tap), .cmd_step(cmd_step),
    .abort(abort), .dly_ld(dly_ld), .dly_cntvaluein(dly_cntvaluein),
    .dly_cntvalueout(dly_cntvalueout), .tap_cur(tap_cur), .busy(busy),
    .step_stb(step_stb), .done(done), .err(err), .err_ch(err_ch),
    .trg_en(trg_en), .trg_out(trg_out)
  );

  always #5 clk = ~clk;

  // Delay-primitive model: a slice captures cntvaluein when its ld strobe is seen at a clock edge
  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (dly_ld[i]) prim[i*TAP_W +: TAP_W] <= dly_cntvaluein[i*TAP_W +: TAP_W];
    end
  end

  assign dly_cntvalueout = force_ch1 ? {prim[19:10], 5'd8, prim[4:0]} : prim;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] allOut();
    return {25'd0, cmd_ready, dly_ld, dly_cntvaluein, tap_cur, busy, step_stb, done, err, err_ch, trg_out};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, holds cmd_valid with a different tap for 3 busy cycles, and records what happens
  task automatic applyStimulus(input int idx, input vec_t v);
    int ld1, ld_count, last_ld, done_cyc, nsteps, step_sum, first_step, last_step;
    logic ready_at_done, busy_after, ready_after;
    ld1 = 0; ld_count = 0; last_ld = -1; done_cyc = -1;
    nsteps = 0; step_sum = 0; first_step = -1; last_step = -1;
    ready_at_done = 1'b1;
    force_ch1   = v.force_ch1;
    cmd_mode    = v.mode;
    cmd_ch_mask = v.mask;
    cmd_tap     = v.tap;
    cmd_step    = v.step;
    cmd_valid   = 1'b1;
    checkOutput($sformatf("v%0d_ready", idx), 64'(cmd_ready), 64'd1);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (cyc <= 3) cmd_tap = v.tap ^ 5'h1F;
      else          cmd_valid = 1'b0;
      if (cyc == 1) ld1 = int'(dly_ld);
      if (dly_ld != 4'd0) begin
        ld_count++;
        last_ld = cyc;
      end
      if (step_stb) begin
        nsteps++;
        step_sum += int'(tap_cur);
        if (first_step < 0) first_step = int'(tap_cur);
        last_step = int'(tap_cur);
      end
      if (done) begin
        done_cyc = cyc;
        ready_at_done = cmd_ready;
        break;
      end
    end
    cmd_valid = 1'b0;
    tick();
    busy_after  = busy;
    ready_after = cmd_ready;
    force_ch1   = 1'b0;
    checkOutput($sformatf("v%0d_ld_at1", idx),      64'(ld1),           64'(v.exp_ld1));
    checkOutput($sformatf("v%0d_ld_count", idx),    64'(ld_count),      64'(v.exp_ld_count));
    checkOutput($sformatf("v%0d_last_ld", idx),     64'(last_ld),       64'(v.exp_last_ld));
    checkOutput($sformatf("v%0d_done_cyc", idx),    64'(done_cyc),      64'(v.exp_done));
    checkOutput($sformatf("v%0d_ready_at_done", idx), 64'(ready_at_done), 64'd0);
    checkOutput($sformatf("v%0d_busy_after", idx),  64'(busy_after),    64'd0);
    checkOutput($sformatf("v%0d_ready_after", idx), 64'(ready_after),   64'd1);
    checkOutput($sformatf("v%0d_nsteps", idx),      64'(nsteps),        64'(v.exp_nsteps));
    checkOutput($sformatf("v%0d_step_sum", idx),    64'(step_sum),      64'(v.exp_step_sum));
    checkOutput($sformatf("v%0d_first_step", idx),  64'(first_step),    64'(v.exp_first));
    checkOutput($sformatf("v%0d_last_step", idx),   64'(last_step),     64'(v.exp_last));
    checkOutput($sformatf("v%0d_err", idx),         64'(err),           64'(v.exp_err));
    checkOutput($sformatf("v%0d_err_ch", idx),      64'(err_ch),        64'(v.exp_err_ch));
    checkOutput($sformatf("v%0d_tap_cur", idx),     64'(tap_cur),       64'(v.exp_tap));
    checkOutput($sformatf("v%0d_cntval", idx),      64'(dly_cntvaluein), 64'(v.exp_cntval));
  endtask

  initial begin
    int dn_cnt, ld_cnt;
    //            mode  mask     tap    step  frc  ld1 ldn last done ns sum first last err ech tap cntval
    vecs[0] = '{2'd0, 4'b0101, 5'd13, 5'd0, 1'b0, 5,  1,  1,  7,  0, 0,  -1, -1, 0, 0, 13, 'h0340D};
    vecs[1] = '{2'd0, 4'b1111, 5'd9,  5'd0, 1'b1, 15, 1,  1,  7,  0, 0,  -1, -1, 1, 2, 9,  'h4A529};
    vecs[2] = '{2'd3, 4'b0010, 5'd7,  5'd0, 1'b0, 2,  1,  1,  7,  0, 0,  -1, -1, 0, 0, 7,  'h4A4E9};
    vecs[3] = '{2'd0, 4'b0000, 5'd3,  5'd0, 1'b0, 0,  0, -1,  7,  0, 0,  -1, -1, 0, 0, 3,  'h4A4E9};
    vecs[4] = '{2'd1, 4'b1111, 5'd20, 5'd4, 1'b0, 15, 3, 45, 67,  3, 72, 20, 28, 0, 0, 28, 'hE739C};
    vecs[5] = '{2'd1, 4'b1111, 5'd29, 5'd0, 1'b0, 15, 3, 45, 67,  3, 90, 29, 31, 0, 0, 31, 'hFFFFF};
    vecs[6] = '{2'd2, 4'b0011, 5'd5,  5'd2, 1'b0, 3,  3, 45, 67,  3, 9,  5,  1,  0, 0, 1,  'hFFC21};
    vecs[7] = '{2'd2, 4'b0100, 5'd0,  5'd3, 1'b0, 4,  1,  1, 23,  1, 0,  0,  0,  0, 0, 0,  'hF8021};

    // Reset held with rdy and trg_en high: every output must still be 0
    tick();
    tick();
    checkOutput("reset_outputs", allOut(), 64'd0);
    trg_en = 1'b0;
    rst_n  = 1'b1;
    tick();
    tick();
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);
    checkOutput("trg_held_off", 64'(trg_out), 64'd0);

    for (int i = 0; i < NV; i++) applyStimulus(i, vecs[i]);

    // Abort during DWELL of an up sweep
    cmd_mode = 2'd1; cmd_ch_mask = 4'b1111; cmd_tap = 5'd2; cmd_step = 5'd1; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      cmd_valid = 1'b0;
    end
    abort = 1'b1;
    checkOutput("abort_dwell_busy_before", 64'(busy), 64'd1);
    tick();
    abort = 1'b0;
    checkOutput("abort_dwell_busy", 64'(busy), 64'd0);
    checkOutput("abort_dwell_tap", 64'(tap_cur), 64'd2);
    checkOutput("abort_dwell_cntval", 64'(dly_cntvaluein), 64'h10842);
    dn_cnt = 0; ld_cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done) dn_cnt++;
      if (dly_ld != 4'd0) ld_cnt++;
      tick();
    end
    checkOutput("abort_dwell_no_done", 64'(dn_cnt), 64'd0);
    checkOutput("abort_dwell_no_ld", 64'(ld_cnt), 64'd0);

    // Abort coinciding with CHECK: mismatch still recorded, step_stb suppressed
    force_ch1 = 1'b1;
    cmd_mode = 2'd1; cmd_ch_mask = 4'b0010; cmd_tap = 5'd6; cmd_step = 5'd1; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      cmd_valid = 1'b0;
    end
    abort = 1'b1;
    #1;
    checkOutput("abort_check_stb", 64'(step_stb), 64'd0);
    tick();
    abort = 1'b0;
    force_ch1 = 1'b0;
    checkOutput("abort_check_busy", 64'(busy), 64'd0);
    checkOutput("abort_check_err", 64'(err), 64'd1);
    checkOutput("abort_check_err_ch", 64'(err_ch), 64'd2);
    checkOutput("abort_check_done", 64'(done), 64'd0);

    // rdy lost during SETTLE of a LOAD
    cmd_mode = 2'd0; cmd_ch_mask = 4'b0001; cmd_tap = 5'd4; cmd_step = 5'd0; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      cmd_valid = 1'b0;
    end
    rdy = 1'b0;
    tick();
    checkOutput("rdy_loss_busy", 64'(busy), 64'd0);
    checkOutput("rdy_loss_err", 64'(err), 64'd1);
    checkOutput("rdy_loss_err_ch", 64'(err_ch), 64'd0);
    checkOutput("rdy_loss_ready", 64'(cmd_ready), 64'd0);
    tick();
    checkOutput("rdy_loss_ready_held", 64'(cmd_ready), 64'd0);
    rdy = 1'b1;
    #1;
    checkOutput("rdy_back_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rdy_back_err_sticky", 64'(err), 64'd1);

    // Test trigger: MSB of a 5-bit counter toggles every 16 cycles
    tick();
    trg_en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (k == 15 || k == 16 || k == 31 || k == 32 || k == 47 || k == 48)
        checkOutput($sformatf("trg_k%0d", k), 64'(trg_out), 64'((k >> 4) & 1));
    end
    trg_en = 1'b0;
    tick();
    checkOutput("trg_off", 64'(trg_out), 64'd0);

    // Asynchronous reset in the middle of a sweep
    trg_en = 1'b1;
    cmd_mode = 2'd1; cmd_ch_mask = 4'b1111; cmd_tap = 5'd0; cmd_step = 5'd8; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      cmd_valid = 1'b0;
    end
    checkOutput("midsweep_tap", 64'(tap_cur), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", allOut(), 64'd0);
    trg_en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ld_cnt = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (dly_ld != 4'd0) ld_cnt++;
    end
    checkOutput("post_reset_no_ld", 64'(ld_cnt), 64'd0);
    checkOutput("post_reset_ready", 64'(cmd_ready), 64'd1);
    checkOutput("post_reset_tap", 64'(tap_cur), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
